// File: rtl/qspi_mem_responder.sv
// qspi_mem_responder: FemtoRV32 memory bus to Quad-SPI bridge for a shared bus
// carrying an SPI flash (read-only, addr[24]=0) and a QSPI PSRAM (addr[24]=1).
// Each request becomes CMD -> ADDR -> [DUMMY] -> DATA, with SCK = clk/2.
// Optional feature macro: QSPI_FLASH_CONT_READ_EN. When defined, flash stays
// selected after a read so that a sequential flash read streams data directly.
module qspi_mem_responder #(
   parameter int FLASH_DUMMY = 6,
   parameter int RAM_DUMMY   = 6,
   parameter int ADDR_WIDTH  = 28
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [31:0]           mem_wdata,
   input  logic [1:0]            mem_write_n,
   input  logic [1:0]            mem_read_n,
   output logic [31:0]           mem_rdata,
   output logic                  mem_ready,
   output logic                  spi_clk_out,
   output logic                  spi_flash_cs_n,
   output logic                  spi_ram_cs_n,
   input  logic [3:0]            spi_data_in,
   output logic [3:0]            spi_data_out,
   output logic [3:0]            spi_data_oe
);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE, S_GAP
   } state_t;

   localparam logic [7:0] FD = 8'(FLASH_DUMMY);
   localparam logic [7:0] RD = 8'(RAM_DUMMY);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;      // SCK index inside the current phase
   logic        ph_q, ph_d;        // 0: SCK low, 1: SCK high
   logic [23:0] addr_q, addr_d;    // device address
   logic        dev_q, dev_d;      // 1 = PSRAM
   logic        wr_q, wr_d;
   logic [2:0]  nb_q, nb_d;        // byte count 1/2/4
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rbuf_q, rbuf_d;    // assembles read bytes during DATA
   logic [31:0] rdata_q, rdata_d;  // visible read data, updated on completion
   logic        cont_q, cont_d;    // flash left selected after a read
`ifdef QSPI_FLASH_CONT_READ_EN
   logic [23:0] nxt_q, nxt_d;      // address that continues the open flash stream
`endif

   logic        rd_req, req, oor;
   logic [1:0]  req_sz;
   logic [2:0]  req_nb;
   logic [7:0]  dlen, last;
   logic [4:0]  nib_idx;
   logic [7:0]  cmd;

   assign rd_req  = (mem_read_n != 2'b11);
   assign req     = rd_req || (mem_write_n != 2'b11);
   assign req_sz  = rd_req ? mem_read_n : mem_write_n;
   assign req_nb  = (req_sz == 2'b00) ? 3'd1 : (req_sz == 2'b01) ? 3'd2 : 3'd4;
   assign oor     = |mem_addr[ADDR_WIDTH-1:25];
   assign dlen    = dev_q ? RD : FD;
   // byte cnt/2 lives at bit 8*(cnt/2); even SCK carries the high nibble
   assign nib_idx = {cnt_q[2:1], ~cnt_q[0], 2'b00};
   assign cmd     = wr_q ? 8'h38 : 8'hEB;

   // last SCK index of the current SPI phase
   always_comb begin
      case (state_q)
         S_CMD:   last = 8'd7;
         S_ADDR:  last = 8'd5;
         S_DUMMY: last = dlen - 8'd1;
         default: last = {4'd0, nb_q, 1'b0} - 8'd1;
      endcase
   end

   // state register and datapath registers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ph_q    <= 1'b0;
         addr_q  <= '0;
         dev_q   <= 1'b0;
         wr_q    <= 1'b0;
         nb_q    <= 3'd1;
         wdata_q <= '0;
         rbuf_q  <= '0;
         rdata_q <= '0;
         cont_q  <= 1'b0;
`ifdef QSPI_FLASH_CONT_READ_EN
         nxt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ph_q    <= ph_d;
         addr_q  <= addr_d;
         dev_q   <= dev_d;
         wr_q    <= wr_d;
         nb_q    <= nb_d;
         wdata_q <= wdata_d;
         rbuf_q  <= rbuf_d;
         rdata_q <= rdata_d;
         cont_q  <= cont_d;
`ifdef QSPI_FLASH_CONT_READ_EN
         nxt_q   <= nxt_d;
`endif
      end
   end

   // next-state: request acceptance, SCK phase sequencing, read capture
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ph_d    = ph_q;
      addr_d  = addr_q;
      dev_d   = dev_q;
      wr_d    = wr_q;
      nb_d    = nb_q;
      wdata_d = wdata_q;
      rbuf_d  = rbuf_q;
      rdata_d = rdata_q;
      cont_d  = cont_q;
`ifdef QSPI_FLASH_CONT_READ_EN
      nxt_d   = nxt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req) begin
               addr_d  = mem_addr[23:0];
               dev_d   = mem_addr[24];
               wr_d    = !rd_req;
               nb_d    = req_nb;
               wdata_d = mem_wdata;
               rbuf_d  = '0;
               cnt_d   = '0;
               ph_d    = 1'b0;
               // out-of-range or flash write: complete without touching the bus
               if (oor || (!rd_req && !mem_addr[24])) begin
                  state_d = S_DONE;
                  cont_d  = 1'b0;
                  rdata_d = '0;
               end
`ifdef QSPI_FLASH_CONT_READ_EN
               else if (cont_q && rd_req && !mem_addr[24] && (mem_addr[23:0] == nxt_q)) begin
                  state_d = S_DATA;
               end else if (cont_q) begin
                  state_d = S_GAP;
                  cont_d  = 1'b0;
               end
`endif
               else begin
                  state_d = S_CMD;
               end
            end
         end
         S_GAP: begin
            // two clk of flash CS high before restarting a full transaction
            if (cnt_q[0]) begin
               cnt_d   = '0;
               state_d = S_CMD;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
            ph_d = ~ph_q;
            if (ph_q) begin
               if (state_q == S_DATA && !wr_q) rbuf_d[nib_idx +: 4] = spi_data_in;
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == last) begin
                  cnt_d = '0;
                  case (state_q)
                     S_CMD:   state_d = S_ADDR;
                     S_ADDR:  state_d = (!wr_q && dlen != 8'd0) ? S_DUMMY : S_DATA;
                     S_DUMMY: state_d = S_DATA;
                     default: begin
                        state_d = S_DONE;
                        rdata_d = wr_q ? 32'd0 : rbuf_d;
`ifdef QSPI_FLASH_CONT_READ_EN
                        cont_d  = !wr_q && !dev_q;
                        nxt_d   = addr_q + 24'(nb_q);
`endif
                     end
                  endcase
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // pin decode from registered state
   always_comb begin
      spi_clk_out    = 1'b0;
      spi_data_out   = 4'h0;
      spi_data_oe    = 4'h0;
      spi_flash_cs_n = !cont_q;
      spi_ram_cs_n   = 1'b1;
      case (state_q)
         S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
            spi_clk_out    = ph_q;
            spi_flash_cs_n = dev_q;
            spi_ram_cs_n   = !dev_q;
         end
         default: ;
      endcase
      case (state_q)
         S_CMD: begin
            spi_data_oe  = 4'b0001;
            spi_data_out = {3'b000, cmd[3'd7 - cnt_q[2:0]]};
         end
         S_ADDR: begin
            spi_data_oe  = 4'hF;
            spi_data_out = addr_q[5'd20 - {cnt_q[2:0], 2'b00} +: 4];
         end
         S_DUMMY: begin
            // flash mode byte 0xFF keeps continuous-read mode off
            if (!dev_q && cnt_q < 8'd2) begin
               spi_data_oe  = 4'hF;
               spi_data_out = 4'hF;
            end
         end
         S_DATA: begin
            if (wr_q) begin
               spi_data_oe  = 4'hF;
               spi_data_out = wdata_q[nib_idx +: 4];
            end
         end
         default: ;
      endcase
   end

   assign mem_ready = (state_q == S_DONE);
   assign mem_rdata = rdata_q;

endmodule
